zbb_bitscan: RTL
================

# zbb_bitscan

Multi-cycle bit-scan responder for the Zbb count instructions (clz, ctz, cpop). The core's execute stage is the initiator: it issues a one-cycle start with the operand and stalls on `busy`. The unit scans the operand a fixed number of bits per cycle and returns the count with a one-cycle `done` pulse. It lets area-constrained configurations drop the single-cycle count trees from the combinational Zbb path while keeping the same results.

## Interface
- `STEP_BITS`, default 4: operand bits examined per RUN cycle. Legal values are 1, 2, 4, 8, 16 and 32. `N = 32 / STEP_BITS` is the RUN length.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request strobe; sampled only when `busy` = 0.
- `op`  in  2  operation: 2'b00 clz, 2'b01 ctz, 2'b10 cpop, 2'b11 reserved.
- `din_rs1`  in  32  operand; sampled together with `start`.
- `busy`  out  1  high while a request is in flight (RUN state).
- `done`  out  1  one-cycle pulse; `dout_rd` is valid in this cycle.
- `dout_rd`  out  32  result, zero-extended; held until the next accepted start.

## Operation
- State machine: IDLE, RUN, DONE.
  - IDLE: `start` = 1 → RUN.
  - RUN: runs exactly N cycles, then → DONE. There is no early termination.
  - DONE: with `start` = 1 → RUN (back-to-back accept); otherwise → IDLE.
- Accept (IDLE or DONE with `start` = 1):
  - Latch `op`.
  - Latch the operand into the shift register. For clz the operand is latched bit-reversed, so all ops scan from LSB upward.
  - Clear the count (6 bits) and the `found` flag.
- Each RUN cycle processes the low STEP_BITS of the shift register, then shifts right by STEP_BITS.
  - cpop: count += popcount of the slice.
  - clz/ctz: if `found` = 0, count += number of trailing zeros in the slice. If the slice contains a one, set `found`. Once `found` = 1, the count is frozen.
  - Reserved op: count stays 0.
- Width rules:
  - Count range is 0..32 (clz/ctz of 0 = 32; cpop of 0xFFFFFFFF = 32).
  - `dout_rd` = {26'b0, count} is loaded on the RUN→DONE transition.
- `start` while `busy` = 1 is ignored. The in-flight request is unaffected and no request is queued.
- `din_rs1` and `op` are don't-care outside accept cycles.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `dout_rd` 0, count 0, `found` 0.
- Latency:
  - `start` sampled high at the end of cycle 0.
  - `busy` = 1 in cycles 1..N.
  - `done` = 1 and the result is valid in cycle N+1. With the default STEP_BITS = 4, `done` is in cycle 9.
- `busy` and `done` are never high in the same cycle.
- `done` is exactly one cycle wide.
- Back-to-back: `start` high during the `done` cycle is accepted, and `busy` rises the next cycle. Throughput is one result per N+1 cycles.
- `dout_rd` is stable from the `done` cycle until N+1 cycles after the next accept. The old value stays visible during the next RUN.
- Reset mid-operation: `rst` high at any edge forces the reset values at that edge, overriding `start`. The aborted request produces no `done`.
- `rst` and `start` in the same cycle: reset wins and the request is dropped.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Single requests, STEP_BITS = 4, each from IDLE, checked in cycle 9 with `done` = 1:
  - clz 0x00010000 → 15
  - ctz 0x00010000 → 16
  - cpop 0xF0F0F0F0 → 16
  - `busy` high in cycles 1..8 for each.
- Boundaries:
  - clz 0 → 32, ctz 0 → 32, cpop 0 → 0.
  - cpop 0xFFFFFFFF → 32.
  - clz 0x80000000 → 0, ctz 0x00000001 → 0.
  - Reserved op 2'b11 with any operand → 0.
- Back-to-back: clz 0x00000F00, then `start` during its `done` cycle with ctz 0x00000F00 → results 20 and 8, with `done` in cycles 9 and 18.
- Ignored start: pulse `start` with different operands in cycles 3 and 5 of a cpop 0x0000000F request → result 4 in cycle 9, and no extra `done` follows.
- Reset mid-op: assert `rst` in cycle 4 of a request → `busy` = 0 and `dout_rd` = 0 next cycle, no `done` appears, and a fresh clz 0x00FF0000 afterwards returns 8.
- Parameter sweep: repeat the first two scenarios for STEP_BITS = 1, 8 and 32 → identical results with `done` in cycles 33, 5 and 2 respectively. Add 1000 random operand/op pairs per setting compared against a reference model.

Source files
------------

// File: rtl/zbb_bitscan.sv
// Multi-cycle bit-scan unit for Zbb clz/ctz/cpop.
// Scans STEP_BITS operand bits per cycle and returns the count with a one-cycle done pulse.
module zbb_bitscan #(
  parameter int unsigned STEP_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] din_rs1,
  output logic        busy,
  output logic        done,
  output logic [31:0] dout_rd
);

  localparam int unsigned N = 32 / STEP_BITS;
  localparam logic [5:0] LastStep = 6'(N - 1);

  localparam logic [1:0] OpClz  = 2'b00;
  localparam logic [1:0] OpCtz  = 2'b01;
  localparam logic [1:0] OpCpop = 2'b10;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q;
  logic [1:0]  op_q;
  logic [31:0] shreg_q;
  logic [5:0]  cnt_q;
  logic        found_q;
  logic [5:0]  step_q;

  logic [STEP_BITS-1:0] slice;
  logic [5:0]           slice_pop;
  logic [5:0]           slice_tz;
  logic                 slice_any;
  logic [5:0]           cnt_d;
  logic                 found_d;
  logic [31:0]          din_rev;
  logic [31:0]          shreg_next;

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      din_rev[i] = din_rs1[31-i];
    end
  end

  assign slice      = shreg_q[STEP_BITS-1:0];
  assign shreg_next = shreg_q >> STEP_BITS;

  // Trailing-zero count stops at the first one; slice_any tracks whether we have passed it.
  always_comb begin
    slice_pop = '0;
    slice_tz  = '0;
    slice_any = 1'b0;
    for (int i = 0; i < int'(STEP_BITS); i++) begin
      if (slice[i]) begin
        slice_pop = slice_pop + 6'd1;
        slice_any = 1'b1;
      end else if (!slice_any) begin
        slice_tz = slice_tz + 6'd1;
      end
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    found_d = found_q;
    unique case (op_q)
      OpClz, OpCtz: begin
        if (!found_q) begin
          cnt_d   = cnt_q + slice_tz;
          found_d = slice_any;
        end
      end
      OpCpop:  cnt_d = cnt_q + slice_pop;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= '0;
      shreg_q <= '0;
      cnt_q   <= '0;
      found_q <= 1'b0;
      step_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dout_rd <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            op_q    <= op;
            shreg_q <= (op == OpClz) ? din_rev : din_rs1;
            cnt_q   <= '0;
            found_q <= 1'b0;
            step_q  <= '0;
            busy    <= 1'b1;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          cnt_q   <= cnt_d;
          found_q <= found_d;
          shreg_q <= shreg_next;
          step_q  <= step_q + 6'd1;
          if (step_q == LastStep) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            dout_rd <= {26'b0, cnt_d};
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
